// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared FSM state, request record and derived burst geometry
package prefetch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int REQ_ADDR_MAX = 64;

    typedef struct packed {
        logic [REQ_ADDR_MAX-1:0] addr;
        logic [15:0]             len;
    } req_t;

    function automatic int beat_bytes(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int burst_bytes(input int data_width, input int burst_beats);
        return beat_bytes(data_width) * burst_beats;
    endfunction

    function automatic int bursts_per_row(input int row_bytes, input int data_width, input int burst_beats);
        return row_bytes / burst_bytes(data_width, burst_beats);
    endfunction

endpackage

// File: rtl/burst_return_tracker.sv
// burst_return_tracker: counts outstanding bursts and beats, writes returned data into the row buffer
module burst_return_tracker
    import prefetch_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_BEATS     = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int BUF_ADDR_WIDTH  = 10,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      active,
    input  logic                      issue,
    input  logic                      rdata_valid,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic                      rdata_last,
    output logic [OW-1:0]             outstanding,
    output logic                      buf_we,
    output logic [BUF_ADDR_WIDTH-1:0] buf_waddr,
    output logic [DATA_WIDTH-1:0]     buf_wdata,
    output logic                      err
);

    localparam int BW = $clog2(BURST_BEATS + 1);

    logic [BW-1:0]             beat_cnt;
    logic [BUF_ADDR_WIDTH-1:0] ptr;
    logic                      beat_ok, stray, burst_end, mismatch;

    // classify the incoming beat: owned by an outstanding burst, stray, or closing a burst
    always_comb begin
        beat_ok   = active && rdata_valid && outstanding != '0;
        stray     = active && rdata_valid && outstanding == '0;
        burst_end = beat_ok && rdata_last;
        mismatch  = beat_ok && (rdata_last != (beat_cnt == BW'(BURST_BEATS - 1)));
    end

    // counters, registered buffer write port and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            outstanding <= '0;
            beat_cnt    <= '0;
            ptr         <= '0;
            buf_we      <= 1'b0;
            buf_waddr   <= '0;
            buf_wdata   <= '0;
            err         <= 1'b0;
        end else begin
            outstanding <= outstanding + OW'(issue) - OW'(burst_end);
            beat_cnt    <= burst_end ? '0 : beat_cnt + BW'(beat_ok);
            buf_we      <= beat_ok;
            if (beat_ok) begin
                buf_waddr <= ptr;
                buf_wdata <= rdata;
                ptr       <= ptr + BUF_ADDR_WIDTH'(1);
            end
            if (stray || mismatch)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/prefetch_burst_engine.sv
// prefetch_burst_engine: splits a row-granular prefetch request into DRAM bursts and lands the data
module prefetch_burst_engine
    import prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int ROW_BYTES       = 256,
    parameter int BURST_BEATS     = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int BUF_ADDR_WIDTH  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [15:0]               req_len,
    output logic                      req_ack,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [7:0]                rd_beats,
    input  logic                      rdata_valid,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic                      rdata_last,
    output logic                      buf_we,
    output logic [BUF_ADDR_WIDTH-1:0] buf_waddr,
    output logic [DATA_WIDTH-1:0]     buf_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int BURST_B = burst_bytes(DATA_WIDTH, BURST_BEATS);
    localparam int BPR     = bursts_per_row(ROW_BYTES, DATA_WIDTH, BURST_BEATS);
    localparam int TW      = 16 + $clog2(BPR + 1);
    localparam int OW      = $clog2(MAX_OUTSTANDING + 1);

    state_t          state, next_state;
    req_t            req;
    logic [TW-1:0]   total, issued;
    logic [OW-1:0]   outstanding;
    logic            capture, issue;

    assign total    = TW'(req.len) * TW'(BPR);
    assign issue    = rd_valid && rd_ready;
    assign rd_addr  = ADDR_WIDTH'(req.addr + REQ_ADDR_MAX'(issued) * REQ_ADDR_MAX'(BURST_B));
    assign rd_beats = 8'(BURST_BEATS);
    assign busy     = state != IDLE;

    // next state, request capture and burst issue window
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        rd_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    capture    = 1'b1;
                    next_state = req_len == '0 ? DONE : RUN;
                end
            end
            RUN: begin
                rd_valid = issued < total && outstanding < OW'(MAX_OUTSTANDING);
                if (issued == total && outstanding == '0)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // captured request, issue counter and registered ack/done pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req     <= '0;
            issued  <= '0;
            req_ack <= 1'b0;
            done    <= 1'b0;
        end else begin
            req_ack <= capture;
            done    <= state == DONE;
            if (capture) begin
                req    <= '{addr: REQ_ADDR_MAX'(req_addr), len: req_len};
                issued <= '0;
            end else if (issue) begin
                issued <= issued + TW'(1);
            end
        end
    end

    burst_return_tracker #(
        .DATA_WIDTH      (DATA_WIDTH),
        .BURST_BEATS     (BURST_BEATS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .BUF_ADDR_WIDTH  (BUF_ADDR_WIDTH)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (capture),
        .active      (state == RUN),
        .issue       (issue),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .outstanding (outstanding),
        .buf_we      (buf_we),
        .buf_waddr   (buf_waddr),
        .buf_wdata   (buf_wdata),
        .err         (err)
    );

endmodule

// File: tb/tb_prefetch_burst_engine.sv
// tb_prefetch_burst_engine: randomized DRAM responder with a queue-based scoreboard
`timescale 1ns/1ps
module tb_prefetch_burst_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic        rd_ready = 1'b0;
    logic        rdata_valid = 1'b0;
    logic [63:0] rdata = '0;
    logic        rdata_last = 1'b0;
    logic        req_ack, rd_valid, buf_we, busy, done, err;
    logic [31:0] rd_addr;
    logic [7:0]  rd_beats;
    logic [9:0]  buf_waddr;
    logic [63:0] buf_wdata;

    int          errors = 0, checks = 0;
    int          ready_pct = 100, beat_pct = 100, ready_limit = 1 << 30;
    bit          beat_en = 1'b1, trunc_next = 1'b0;
    logic [31:0] exp_rd[$];
    int          exp_wa[$];
    logic [63:0] exp_wd[$];
    int          pending[$];
    int          exp_done = 0, done_cnt = 0, req_done_base = 0;
    int          hs_cnt = 0, wr_cnt = 0, acc_cnt = 0, mon_out = 0, beat_idx = 0;
    logic [9:0]  wp = '0;
    longint      ack_t = 0, done_t = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    prefetch_burst_engine dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ack(req_ack), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_beats(rd_beats), .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // DRAM model: accepts bursts, returns beats in order, feeds expected buffer writes
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                acc_cnt++;
                pending.push_back(trunc_next ? 10 : 16);
                trunc_next = 1'b0;
            end
            if (rdata_valid) begin
                if (rdata_last) begin
                    void'(pending.pop_front());
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
            @(posedge clk);
            #1;
            rd_ready = (acc_cnt < ready_limit) && ($urandom_range(0, 99) < ready_pct);
            if (beat_en && pending.size() > 0 && $urandom_range(0, 99) < beat_pct) begin
                rdata_valid = 1'b1;
                rdata       = {$urandom, $urandom};
                rdata_last  = beat_idx == pending[0] - 1;
                exp_wa.push_back(int'(wp));
                exp_wd.push_back(rdata);
                wp++;
            end else begin
                rdata_valid = 1'b0;
                rdata_last  = 1'b0;
            end
        end
    end

    // monitor: pops expected bursts, writes and done pulses as the DUT presents them
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_out    = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("rd_hold_valid", rd_valid, 1);
                    check("rd_hold_addr", rd_addr, prev_addr);
                end
                if (rd_valid && rd_ready) begin
                    hs_cnt++;
                    check("outstanding_cap", mon_out < 4, 1);
                    check("rd_expected", exp_rd.size() != 0, 1);
                    if (exp_rd.size() != 0)
                        check("rd_addr", rd_addr, exp_rd.pop_front());
                    mon_out++;
                end
                if (rdata_valid && rdata_last && mon_out > 0)
                    mon_out--;
                if (buf_we) begin
                    wr_cnt++;
                    check("wr_expected", exp_wa.size() != 0, 1);
                    if (exp_wa.size() != 0) begin
                        check("buf_waddr", buf_waddr, exp_wa.pop_front());
                        check("buf_wdata", buf_wdata, exp_wd.pop_front());
                    end
                end
                if (done) begin
                    done_t = $time;
                    check("done_expected", exp_done > 0, 1);
                    if (exp_done > 0)
                        exp_done--;
                    done_cnt++;
                end
                prev_stall = rd_valid && !rd_ready;
                prev_addr  = rd_addr;
            end
        end
    end

    task automatic start_req(input logic [31:0] base, input int len);
        bit got;
        for (int k = 0; k < len * 2; k++)
            exp_rd.push_back(base + 32'(k * 128));
        wp            = '0;
        hs_cnt        = 0;
        wr_cnt        = 0;
        acc_cnt       = 0;
        exp_done++;
        req_done_base = done_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = base;
        req_len   = 16'(len);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = req_ack;
        end
        ack_t = $time;
        check("req_ack_seen", got, 1);
        check("busy_at_ack", busy, 1);
        check("err_clear_at_ack", err, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("req_ack_pulse", req_ack, 0);
    endtask

    task automatic finish_req(input logic exp_err, input int exp_writes);
        for (int c = 0; c < 10000 && done_cnt == req_done_base; c++)
            @(negedge clk);
        check("done_seen", done_cnt - req_done_base, 1);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt - req_done_base, 1);
        check("err_final", err, exp_err);
        check("wr_count", wr_cnt, exp_writes);
        check("rd_left", exp_rd.size(), 0);
        check("wr_left", exp_wa.size(), 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic run(input logic [31:0] base, input int len, input logic exp_err, input int exp_writes);
        start_req(base, len);
        finish_req(exp_err, exp_writes);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ack", req_ack, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_buf_we", buf_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rd_beats", rd_beats, 16);

        run(32'h1000_0000, 4, 1'b0, 128);

        start_req(32'h1800_0000, 0);
        finish_req(1'b0, 0);
        check("len0_done_delay", done_t - ack_t, 10);

        ready_pct = 0;
        beat_en   = 1'b0;
        start_req(32'h2000_0000, 4);
        repeat (6) @(negedge clk);
        check("stall_valid", rd_valid, 1);
        ready_pct = 100;
        repeat (15) @(negedge clk);
        check("cap_hs", hs_cnt, 4);
        check("cap_valid_low", rd_valid, 0);
        beat_pct  = 50;
        ready_pct = 70;
        beat_en   = 1'b1;
        finish_req(1'b0, 128);

        ready_pct  = 100;
        beat_pct   = 100;
        trunc_next = 1'b1;
        run(32'h3000_0040, 2, 1'b1, 58);
        run(32'h4000_0000, 1, 1'b0, 32);
        run(32'hFFFF_FF80, 1, 1'b0, 32);

        for (int i = 0; i < 4; i++) begin
            int len;
            len       = int'($urandom_range(1, 6));
            ready_pct = int'($urandom_range(30, 100));
            beat_pct  = int'($urandom_range(30, 100));
            run($urandom, len, 1'b0, len * 32);
        end

        ready_pct   = 100;
        beat_en     = 1'b0;
        ready_limit = 3;
        start_req(32'h5000_0000, 4);
        for (int c = 0; c < 50 && hs_cnt < 3; c++)
            @(negedge clk);
        check("rst_mid_hs", hs_cnt, 3);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_rd.delete();
        pending.delete();
        beat_idx = 0;
        exp_done--;
        @(negedge clk);
        check("mid_rst_req_ack", req_ack, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_rd_addr", rd_addr, 0);
        check("mid_rst_buf_we", buf_we, 0);
        check("mid_rst_buf_waddr", buf_waddr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        repeat (5) @(negedge clk);
        check("mid_rst_still_idle", busy, 0);
        ready_limit = 1 << 30;
        beat_en     = 1'b1;
        run(32'h6000_0000, 1, 1'b0, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/prefetch_burst_engine.md
Name: prefetch_burst_engine

Overview:
- Sits directly downstream of the split prefetcher. Accepts its row-granular read request (base addr, len in rows) and acknowledges it.
- Splits the request into fixed-size DRAM read bursts and tracks outstanding bursts.
- Writes returned data beats into the reference-row buffer, then pulses done when the whole region has landed.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 64, DRAM data beat width (bits; multiple of 8)
- ROW_BYTES, 256, bytes per reference row (multiple of burst bytes)
- BURST_BEATS, 16, beats per DRAM burst
- MAX_OUTSTANDING, 4, max bursts issued but not fully returned
- BUF_ADDR_WIDTH, 10, row-buffer word address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  prefetch request (held high until req_ack)
- req_addr  in  ADDR_WIDTH  region base byte address
- req_len  in  16  region length in rows
- req_ack  out  1  one-cycle pulse: request captured
- rd_valid  out  1  DRAM burst read request valid
- rd_ready  in  1  DRAM accepts burst
- rd_addr  out  ADDR_WIDTH  burst byte address
- rd_beats  out  8  beats in burst (constant BURST_BEATS)
- rdata_valid  in  1  return beat valid
- rdata  in  DATA_WIDTH  return beat data
- rdata_last  in  1  last beat of a burst
- buf_we  out  1  row-buffer write enable
- buf_waddr  out  BUF_ADDR_WIDTH  row-buffer write address
- buf_wdata  out  DATA_WIDTH  row-buffer write data
- busy  out  1  request in progress
- done  out  1  one-cycle pulse: all beats written
- err  out  1  sticky beat/last mismatch or unexpected beat

Behaviour:
- Reset (rst_n low at posedge): all outputs and counters are 0, and state is IDLE. Reset mid-request abandons it. No done is issued; data beats arriving later are ignored until the next accept.
- Derived constants:
  - BEAT_BYTES = DATA_WIDTH/8
  - BURST_BYTES = BEAT_BYTES*BURST_BEATS
  - BPR = ROW_BYTES/BURST_BYTES
  - total_bursts = req_len*BPR, computed at full width with no truncation
- FSM states: IDLE, RUN, DONE.
- IDLE: if req_valid is high, capture addr/len, zero all counters and buf_waddr, and clear err. req_ack is 1 in the following cycle (registered pulse). Go to RUN, or to DONE if req_len==0.
- req_valid is ignored outside IDLE, so the requester's held-high cycle after the ack is not recaptured.
- RUN, issue side:
  - rd_valid is high while issued<total_bursts and outstanding<MAX_OUTSTANDING.
  - rd_addr = base + issued*BURST_BYTES, modulo 2^ADDR_WIDTH.
  - rd_valid and rd_addr stay stable until rd_ready.
  - A burst is issued on rd_valid&&rd_ready: issued++ and outstanding++.
- RUN, data side:
  - Each rdata_valid beat drives buf_we=1, buf_wdata=rdata, buf_waddr=current pointer, registered with 1-cycle latency. The pointer then increments and wraps at 2^BUF_ADDR_WIDTH.
  - A beat counter within the burst tracks position.
  - When rdata_last is seen, outstanding-- and the beat counter resets.
  - If rdata_last does not coincide with beat BURST_BEATS-1, set err and treat the burst as ended on rdata_last.
  - A beat arriving while outstanding==0 sets err and is not written.
- Same-cycle issue and last: outstanding stays unchanged.
- RUN -> DONE when issued==total_bursts and outstanding==0, after the final beat's write has been presented.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy = (state != IDLE).
- No backpressure on the data return or buffer write path: the buffer always accepts.

Decomposition:
- Shared package prefetch_pkg: FSM state enum, BEAT_BYTES/BURST_BYTES/BPR localparam functions, and the request struct (addr, len).
- One natural sub-module, burst_return_tracker. It holds the beat counter, outstanding counter, buffer pointer and err logic. The top holds the FSM and issue path.

Test Plan:
- Defaults (8 B/beat, 128 B/burst, BPR=2), req_addr=0x1000_0000, len=4, rd_ready=1, data returns in order -> req_ack one pulse; 8 bursts at 0x1000_0000, +0x80, …, 0x1000_0380; 128 buf writes at addr 0..127; single done; err=0.
- len=0 -> req_ack, done two cycles after capture, no rd_valid, no buf_we.
- rd_ready low, data delayed -> rd_valid holds with a stable addr; at most 4 bursts outstanding; the 5th rd_valid stays low until the first rdata_last.
- Truncated burst: rdata_last on beat 9 -> err=1 and stays 1; the request still completes; the next accepted request clears err.
- Base 0xFFFF_FF80, len=1 -> rd_addr 0xFFFF_FF80 then 0x0000_0000 (wrap).
- rst_n low for 1 cycle after 3 bursts issued -> all outputs 0; no done; a subsequent len=1 request completes normally with buf_waddr starting at 0.
